// File: rtl/dpc_pkg.sv
// Shared types for the opcode dispatcher: opcode encoding, FSM states, scan modes.
package dpc_pkg;

    localparam int OPCODE_FIELD_W = 4;

    typedef enum logic [OPCODE_FIELD_W-1:0] {
        OP_NOP   = 4'h0,
        OP_INC   = 4'h1,
        OP_DEC   = 4'h2,
        OP_RIGHT = 4'h3,
        OP_LEFT  = 4'h4,
        OP_LOOP  = 4'h5,
        OP_END   = 4'h6,
        OP_OUT   = 4'h7,
        OP_IN    = 4'h8,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_CMD_WAIT,
        ST_IP_WAIT,
        ST_HALT
    } disp_state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL,
        MODE_SCAN_FWD,
        MODE_SCAN_BACK
    } scan_mode_t;

endpackage

// File: rtl/opcode_dispatcher_bracket_counter.sv
// Bracket nesting-depth counter: load-to-one, up/down, zero and full flags.
// ovf_o flags that one more increment would overflow the counter.
module bracket_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load1_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o,
    output logic         ovf_o
);

    logic [W-1:0] count_q;

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);
    assign ovf_o   = &count_q;

    // Depth register; saturates at both ends so it never wraps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                    count_q <= '0;
        else if (load1_i)             count_q <= W'(1);
        else if (inc_i && !ovf_o)     count_q <= count_q + W'(1);
        else if (dec_i && !zero_o)    count_q <= count_q - W'(1);
    end

endmodule

// File: rtl/opcode_dispatcher.sv
// Opcode dispatcher: accepts opcodes from the IP line, issues step/direction
// pulses to the AP, data, I/O and IP lines, and scans for matching brackets.
// Optional feature macro DPC_IO_EN: when defined, '.'/',' pulse IoOut/IoIn;
// otherwise they behave as NOP and the I/O outputs are tied low.
module opcode_dispatcher
    import dpc_pkg::*;
#(
    parameter int LOOP_DEPTH_W = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] Opcode,
    input  logic        OpValid,
    output logic        OpReady,
    input  logic        DataZero,
    input  logic        LineDone,
    output logic        IpStep,
    output logic        IpReverse,
    output logic        ApStep,
    output logic        ApReverse,
    output logic        DataStep,
    output logic        DataReverse,
    output logic        IoOut,
    output logic        IoIn,
    output logic        Halted,
    output logic        LoopError
);

    disp_state_t state_q, state_d;
    scan_mode_t  mode_q, mode_d;
    logic ip_step_q, ip_step_d, ip_rev_q, ip_rev_d;
    logic ap_step_q, ap_step_d, ap_rev_q, ap_rev_d;
    logic data_step_q, data_step_d, data_rev_q, data_rev_d;
    logic halted_q, halted_d, loop_err_q, loop_err_d;
`ifdef DPC_IO_EN
    logic io_out_q, io_out_d, io_in_q, io_in_d;
`endif

    logic                    cnt_load, cnt_inc, cnt_dec;
    logic [LOOP_DEPTH_W-1:0] depth;
    logic                    depth_zero, depth_full;
    opcode_t                 op;
    logic                    accept, line_done, pulse_q, scan_inc, scan_dec;
    logic                    unused_ok;

    bracket_counter #(.W(LOOP_DEPTH_W)) u_depth (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .load1_i (cnt_load),
        .inc_i   (cnt_inc),
        .dec_i   (cnt_dec),
        .count_o (depth),
        .zero_o  (depth_zero),
        .ovf_o   (depth_full)
    );

    assign op     = opcode_t'(Opcode[OPCODE_FIELD_W-1:0]);
    assign accept = OpValid && (state_q == ST_FETCH);
`ifdef DPC_IO_EN
    assign pulse_q = ip_step_q | ap_step_q | data_step_q | io_out_q | io_in_q;
`else
    assign pulse_q = ip_step_q | ap_step_q | data_step_q;
`endif
    // A LineDone coinciding with our own pulse belongs to an earlier step.
    assign line_done = LineDone && !pulse_q;
    assign scan_inc  = (mode_q == MODE_SCAN_FWD  && op == OP_LOOP) ||
                       (mode_q == MODE_SCAN_BACK && op == OP_END);
    assign scan_dec  = (mode_q == MODE_SCAN_FWD  && op == OP_END) ||
                       (mode_q == MODE_SCAN_BACK && op == OP_LOOP);
    assign unused_ok = ^{Opcode[15:OPCODE_FIELD_W], depth_zero};

    // Next-state decode: instruction dispatch, bracket scanning and line waits.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        ip_step_d   = 1'b0;
        ip_rev_d    = ip_rev_q;
        ap_step_d   = 1'b0;
        ap_rev_d    = ap_rev_q;
        data_step_d = 1'b0;
        data_rev_d  = data_rev_q;
        halted_d    = halted_q;
        loop_err_d  = loop_err_q;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
        cnt_dec     = 1'b0;
`ifdef DPC_IO_EN
        io_out_d    = 1'b0;
        io_in_d     = 1'b0;
`endif
        case (state_q)
            ST_FETCH: if (accept) begin
                if (mode_q == MODE_NORMAL) begin
                    state_d = ST_CMD_WAIT;
                    case (op)
                        OP_INC, OP_DEC: begin
                            data_step_d = 1'b1;
                            data_rev_d  = (op == OP_DEC);
                        end
                        OP_RIGHT, OP_LEFT: begin
                            ap_step_d = 1'b1;
                            ap_rev_d  = (op == OP_LEFT);
                        end
`ifdef DPC_IO_EN
                        OP_OUT: io_out_d = 1'b1;
                        OP_IN:  io_in_d  = 1'b1;
`endif
                        OP_LOOP: begin
                            state_d   = ST_IP_WAIT;
                            ip_step_d = 1'b1;
                            if (DataZero) begin
                                cnt_load = 1'b1;
                                mode_d   = MODE_SCAN_FWD;
                            end
                        end
                        OP_END: begin
                            state_d   = ST_IP_WAIT;
                            ip_step_d = 1'b1;
                            if (!DataZero) begin
                                cnt_load = 1'b1;
                                mode_d   = MODE_SCAN_BACK;
                                ip_rev_d = 1'b1;
                            end
                        end
                        OP_HALT: begin
                            state_d  = ST_HALT;
                            halted_d = 1'b1;
                        end
                        default: begin
                            state_d   = ST_IP_WAIT;
                            ip_step_d = 1'b1;
                        end
                    endcase
                end else if (op == OP_HALT || (scan_inc && depth_full)) begin
                    // Ran off the program or nested too deep: fatal, no pulse.
                    state_d    = ST_HALT;
                    halted_d   = 1'b1;
                    loop_err_d = 1'b1;
                end else begin
                    state_d   = ST_IP_WAIT;
                    ip_step_d = 1'b1;
                    cnt_inc   = scan_inc;
                    cnt_dec   = scan_dec;
                    // Matching bracket found: step forward past it.
                    if (scan_dec && depth == LOOP_DEPTH_W'(1)) begin
                        mode_d   = MODE_NORMAL;
                        ip_rev_d = 1'b0;
                    end
                end
            end
            ST_CMD_WAIT: if (line_done) begin
                ip_step_d = 1'b1;
                state_d   = ST_IP_WAIT;
            end
            ST_IP_WAIT: if (line_done) state_d = ST_FETCH;
            default: ;
        endcase
    end

    // State and registered outputs; reset drops any in-flight pulse.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_FETCH;
            mode_q      <= MODE_NORMAL;
            ip_step_q   <= 1'b0;
            ip_rev_q    <= 1'b0;
            ap_step_q   <= 1'b0;
            ap_rev_q    <= 1'b0;
            data_step_q <= 1'b0;
            data_rev_q  <= 1'b0;
            halted_q    <= 1'b0;
            loop_err_q  <= 1'b0;
`ifdef DPC_IO_EN
            io_out_q    <= 1'b0;
            io_in_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            ip_step_q   <= ip_step_d;
            ip_rev_q    <= ip_rev_d;
            ap_step_q   <= ap_step_d;
            ap_rev_q    <= ap_rev_d;
            data_step_q <= data_step_d;
            data_rev_q  <= data_rev_d;
            halted_q    <= halted_d;
            loop_err_q  <= loop_err_d;
`ifdef DPC_IO_EN
            io_out_q    <= io_out_d;
            io_in_q     <= io_in_d;
`endif
        end
    end

    assign OpReady     = (state_q == ST_FETCH);
    assign IpStep      = ip_step_q;
    assign IpReverse   = ip_rev_q;
    assign ApStep      = ap_step_q;
    assign ApReverse   = ap_rev_q;
    assign DataStep    = data_step_q;
    assign DataReverse = data_rev_q;
    assign Halted      = halted_q;
    assign LoopError   = loop_err_q;
`ifdef DPC_IO_EN
    assign IoOut       = io_out_q;
    assign IoIn        = io_in_q;
`else
    assign IoOut       = 1'b0;
    assign IoIn        = 1'b0;
`endif

endmodule

// File: tb/tb_opcode_dispatcher.sv
// Bench for opcode_dispatcher: an interpreter of the bracket language predicts
// the exact pulse/direction sequence; the bench also emulates the IP, AP and
// data lines with random LineDone latency and random OpValid gaps.
module tb_opcode_dispatcher;

    localparam int DW     = 3;
    localparam int DMAX   = (1 << DW) - 1;
    localparam int CAP    = 200;
    localparam int BUDGET = 4000;
`ifdef DPC_IO_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic        Clk = 1'b0, Rst = 1'b1;
    logic [15:0] Opcode = '0;
    logic        OpValid = 1'b0, DataZero = 1'b0, LineDone = 1'b0;
    logic        OpReady, IpStep, IpReverse, ApStep, ApReverse;
    logic        DataStep, DataReverse, IoOut, IoIn, Halted, LoopError;

    opcode_dispatcher #(.LOOP_DEPTH_W(DW)) dut (
        .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .OpValid(OpValid), .OpReady(OpReady),
        .DataZero(DataZero), .LineDone(LineDone), .IpStep(IpStep), .IpReverse(IpReverse),
        .ApStep(ApStep), .ApReverse(ApReverse), .DataStep(DataStep), .DataReverse(DataReverse),
        .IoOut(IoOut), .IoIn(IoIn), .Halted(Halted), .LoopError(LoopError)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0, n_fail = 0;
    logic [3:0] prog [0:255];
    int plen;
    // Event code = kind*2 + reverse; kind 0 IP, 1 AP, 2 DATA, 3 IoOut, 4 IoIn.
    int exp_q[$];
    bit exp_halt, exp_err;
    bit chk_en = 1'b0;
    int cyc, cn, cev;
    int cmd_cyc[$];

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic logic [3:0] prog_at(input int i);
        return (i < 0 || i >= plen) ? 4'hF : prog[i];
    endfunction

    task automatic load(input string s);
        plen = s.len();
        for (int i = 0; i < plen; i++) begin
            case (s[i])
                "+": prog[i] = 4'h1;
                "-": prog[i] = 4'h2;
                ">": prog[i] = 4'h3;
                "<": prog[i] = 4'h4;
                "[": prog[i] = 4'h5;
                "]": prog[i] = 4'h6;
                ".": prog[i] = 4'h7;
                ",": prog[i] = 4'h8;
                "F": prog[i] = 4'hF;
                "x": prog[i] = 4'hB;
                default: prog[i] = 4'h0;
            endcase
        end
    endtask

    // Interpreter: walks the program as the language defines it and lists
    // every pulse the dispatcher must produce, in order.
    task automatic model_run();
        logic [7:0] mem [256];
        int ip, ap, depth;
        logic [3:0] op;
        foreach (mem[i]) mem[i] = 8'd0;
        ip = 0; ap = 0;
        exp_q.delete(); exp_halt = 0; exp_err = 0;
        while (exp_q.size() < CAP && !exp_halt) begin
            op = prog_at(ip);
            case (op)
                4'h1: begin exp_q.push_back(4); exp_q.push_back(0); mem[ap & 255]++; ip++; end
                4'h2: begin exp_q.push_back(5); exp_q.push_back(0); mem[ap & 255]--; ip++; end
                4'h3: begin exp_q.push_back(2); exp_q.push_back(0); ap++; ip++; end
                4'h4: begin exp_q.push_back(3); exp_q.push_back(0); ap--; ip++; end
                4'h5: begin
                    exp_q.push_back(0); ip++;
                    if (mem[ap & 255] == 0) begin
                        depth = 1;
                        while (depth != 0 && !exp_halt) begin
                            op = prog_at(ip);
                            if (op == 4'hF) begin exp_halt = 1; exp_err = 1; end
                            else if (op == 4'h5 && depth == DMAX) begin exp_halt = 1; exp_err = 1; end
                            else begin
                                if (op == 4'h5) depth++;
                                if (op == 4'h6) depth--;
                                exp_q.push_back(0); ip++;
                            end
                        end
                    end
                end
                4'h6: begin
                    if (mem[ap & 255] == 0) begin exp_q.push_back(0); ip++; end
                    else begin
                        exp_q.push_back(1); ip--; depth = 1;
                        while (depth != 0 && !exp_halt) begin
                            op = prog_at(ip);
                            if (op == 4'hF) begin exp_halt = 1; exp_err = 1; end
                            else if (op == 4'h6 && depth == DMAX) begin exp_halt = 1; exp_err = 1; end
                            else begin
                                if (op == 4'h6) depth++;
                                if (op == 4'h5) depth--;
                                if (depth == 0) begin exp_q.push_back(0); ip++; end
                                else begin exp_q.push_back(1); ip--; end
                            end
                        end
                    end
                end
                4'h7: begin if (IO_EN) exp_q.push_back(6); exp_q.push_back(0); ip++; end
                4'h8: begin if (IO_EN) exp_q.push_back(8); exp_q.push_back(0); ip++; end
                4'hF: exp_halt = 1;
                default: begin exp_q.push_back(0); ip++; end
            endcase
        end
    endtask

    // Compare process: every pulse must be single, with OpReady low, and
    // match the next predicted event including its direction.
    always @(negedge Clk) begin
        if (chk_en && !Rst) begin
            cyc++;
            cn = int'(IpStep) + int'(ApStep) + int'(DataStep) + int'(IoOut) + int'(IoIn);
            if (cn != 0) begin
                cev = IpStep ? int'(IpReverse) : ApStep ? 2 + int'(ApReverse) :
                      DataStep ? 4 + int'(DataReverse) : IoOut ? 6 : 8;
                n_chk++;
                if (cn != 1 || OpReady || exp_q.size() == 0 || cev != exp_q[0]) begin
                    n_fail++;
                    $display("FAIL pulse: got event %0d (count %0d ready %0b) expected %0d",
                             cev, cn, OpReady, exp_q.size() != 0 ? exp_q[0] : -1);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (ApStep || DataStep) cmd_cyc.push_back(cyc);
            end
        end
    end

    task automatic do_reset();
        Rst = 1'b1; OpValid = 1'b0; LineDone = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
    endtask

    // Drive the predicted program through the DUT while emulating the lines.
    task automatic run_prog(input int vpct, input int maxd, input bit spur);
        logic [7:0] em [256];
        logic [31:0] rnd;
        int eip, eap, pend, hseen;
        bit ld, done;
        foreach (em[i]) em[i] = 8'd0;
        eip = 0; eap = 0; pend = -1; hseen = 0; done = 0;
        do_reset();
        cyc = 0; cmd_cyc.delete(); chk_en = 1'b1;
        for (int c = 0; c < BUDGET && !done; c++) begin
            @(negedge Clk);
            if (IpStep)   eip += IpReverse ? -1 : 1;
            if (ApStep)   eap += ApReverse ? -1 : 1;
            if (DataStep) em[eap & 255] = DataReverse ? em[eap & 255] - 8'd1 : em[eap & 255] + 8'd1;
            ld = 1'b0;
            if (IpStep || ApStep || DataStep || IoOut || IoIn) begin
                pend = $urandom_range(maxd, 0);
                ld   = spur && ($urandom_range(1, 0) == 1);
            end else if (pend == 0) begin
                ld = 1'b1; pend = -1;
            end else if (pend > 0) begin
                pend--;
            end else if (OpReady && spur) begin
                ld = ($urandom_range(3, 0) == 0);
            end
            rnd      = $urandom;
            LineDone = ld;
            OpValid  = ($urandom_range(99, 0) < vpct);
            Opcode   = {rnd[15:4], prog_at(eip)};
            DataZero = OpReady ? (em[eap & 255] == 8'd0) : rnd[20];
            if (exp_halt && Halted) hseen++;
            if (hseen > 12 || (!exp_halt && exp_q.size() == 0)) done = 1;
        end
        chk_en = 1'b0;
        chk("finished_in_budget", int'(done), 1);
        if (exp_halt) begin
            chk("halted", int'(Halted), 1);
            chk("loop_error", int'(LoopError), int'(exp_err));
            chk("ready_in_halt", int'(OpReady), 0);
        end
        chk("events_left", exp_q.size(), 0);
        OpValid = 1'b0; LineDone = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lit[8];
        int cnt, ok;
        bit saw;
        string alpha;
        string s;

        // Reset values.
        do_reset();
        chk("rst_ready", int'(OpReady), 1);
        chk("rst_halted", int'(Halted), 0);
        chk("rst_looperr", int'(LoopError), 0);
        chk("rst_pulses", int'(IpStep) + int'(ApStep) + int'(DataStep) + int'(IoOut) + int'(IoIn), 0);
        chk("rst_dirs", int'(IpReverse) + int'(ApReverse) + int'(DataReverse), 0);

        // Straight-line program, immediate LineDone: order and 5-cycle period.
        load("+>-<F");
        model_run();
        lit = '{4, 0, 2, 0, 5, 0, 3, 0};
        ok = (exp_q.size() == 8);
        for (int i = 0; i < 8 && ok != 0; i++) if (exp_q[i] != lit[i]) ok = 0;
        chk("model_basic_order", ok, 1);
        run_prog(100, 0, 0);
        chk("cmd_pulse_count", cmd_cyc.size(), 4);
        for (int i = 1; i < cmd_cyc.size(); i++) chk("instr_period", cmd_cyc[i] - cmd_cyc[i-1], 5);

        // Forward skip over nested loop body.
        load("[+[-]]+F");
        model_run();
        chk("model_skip_events", exp_q.size(), 8);
        cnt = 0;
        foreach (exp_q[i]) if ((exp_q[i] >> 1) == 2) cnt++;
        chk("model_skip_data", cnt, 1);
        run_prog(70, 2, 1);

        // Backward scan, landing after the '['.
        load("+>+<[>]F");
        model_run();
        chk("model_back_events", exp_q.size(), 17);
        cnt = 0;
        foreach (exp_q[i]) if (exp_q[i] == 1) cnt++;
        chk("model_back_rev", cnt, 2);
        run_prog(70, 2, 1);

        // Depth overflow.
        load("[[[[[[[[F");
        model_run();
        chk("model_ovf_events", exp_q.size(), 7);
        chk("model_ovf_err", int'(exp_err), 1);
        run_prog(80, 1, 1);

        // Unmatched bracket runs into HALT.
        load("[+F");
        model_run();
        chk("model_unmatched_err", int'(exp_err), 1);
        run_prog(80, 1, 1);

        // HALT, OpValid ignored afterwards, then reset recovers.
        load("F");
        model_run();
        run_prog(100, 0, 0);
        do_reset();
        chk("after_halt_ready", int'(OpReady), 1);
        chk("after_halt_halted", int'(Halted), 0);

        // I/O opcodes plus reserved codes treated as NOP.
        load(".x,F");
        model_run();
        chk("model_io_events", exp_q.size(), IO_EN ? 5 : 3);
        run_prog(100, 0, 0);

        // Reset in the middle of a pulse clears outputs at once.
        do_reset();
        OpValid = 1'b1; Opcode = 16'h0002;
        saw = 0;
        for (int i = 0; i < 10 && !saw; i++) begin
            @(negedge Clk);
            if (DataStep) saw = 1;
        end
        chk("midrst_pulse_seen", int'(saw), 1);
        Rst = 1'b1;
        #1;
        chk("midrst_pulse_dropped", int'(DataStep), 0);
        chk("midrst_dir_cleared", int'(DataReverse), 0);
        chk("midrst_ready", int'(OpReady), 1);
        @(negedge Clk);
        Rst = 1'b0; OpValid = 1'b0;

        // Random programs.
        alpha = "++-><[]]..,x[+";
        for (int p = 0; p < 25; p++) begin
            int len;
            len = $urandom_range(20, 6);
            s = "";
            for (int i = 0; i < len; i++) begin
                int k;
                k = $urandom_range(alpha.len() - 1, 0);
                s = {s, string'(alpha[k])};
            end
            s = {s, "F"};
            load(s);
            model_run();
            run_prog(60, 3, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
